mem_port_arbiter: RTL and testbench

Sequential arbiter that shares one single-port, fixed-latency unified memory between the pipeline's instruction-fetch (IF) port and data (MEM-stage load/store) port. It grants one requester at a time, sequences the multi-cycle access with a latency counter and returns data with a one-cycle ready pulse. It drives per-port stall signals that feed the hazard logic (PC write / IF/ID write gating and MEM-stage hold). It also keeps a saturating contention counter for performance debug.

---
 rtl/mem_port_arbiter_pkg.sv | 36 +++
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_port_arbiter_latency_counter.sv | 26 ++
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/data unified-memory arbiter.
package mem_arb_pkg;

   localparam int unsigned ADDR_W    = 32;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned LCNT_W    = 4;
   localparam int unsigned LAT_MIN   = 1;
   localparam int unsigned LAT_MAX   = 15;
   localparam int unsigned CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_D  = 2'd2
   } arb_state_t;

   typedef enum logic {
      SEL_IF = 1'b0,
      SEL_D  = 1'b1
   } port_sel_t;

   // Command latched into the memory-side registers on a grant
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_cmd_t;

   // Keep the latency inside what the 4-bit access counter can reach
   function automatic int unsigned clamp_latency(input int unsigned lat);
      if (lat < LAT_MIN) return LAT_MIN;
      if (lat > LAT_MAX) return LAT_MAX;
      return lat;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and memory port of the unified-memory arbiter.
interface mem_port_arbiter_if;
   import mem_arb_pkg::*;

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ready;
   logic              if_stall;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ready;
   logic              d_stall;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
             mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_port_arbiter_latency_counter.sv
// Access latency counter: loads 1 on start, counts while busy, flags the last cycle.
module mem_latency_counter
   import mem_arb_pkg::*;
#(
   parameter int unsigned MEM_LATENCY = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic inc,
   output logic done_c
);

   logic [LCNT_W-1:0] cnt;

   // Counter returns to 0 whenever no access is in flight
   always_ff @(posedge clk) begin
      if (!rst_n)     cnt <= '0;
      else if (start) cnt <= LCNT_W'(1);
      else if (inc)   cnt <= cnt + LCNT_W'(1);
      else            cnt <= '0;
   end

   assign done_c = (cnt == LCNT_W'(MEM_LATENCY));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data ports onto one fixed-latency single-port memory.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned MEM_LATENCY = 2,
   parameter int unsigned CNT_W       = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              startin,
   mem_port_arbiter_if.slave bus,
   output logic [CNT_W-1:0]  contention_cnt
);

   localparam int unsigned LAT = clamp_latency(MEM_LATENCY);

   arb_state_t state, state_n;
   mem_cmd_t   cmd, cmd_n, if_cmd, d_cmd;
   logic       en, en_n;
   logic       start, inc, go, done_c;
   port_sel_t  sel;
   logic       cmp_if, cmp_d;

   mem_latency_counter #(.MEM_LATENCY(LAT)) u_lat (
      .clk    (clk),
      .rst_n  (startin),
      .start  (start),
      .inc    (inc),
      .done_c (done_c)
   );

   assign if_cmd = '{we: 1'b0, addr: bus.if_addr, wdata: DATA_W'(0)};
   assign d_cmd  = '{we: bus.d_we, addr: bus.d_addr, wdata: bus.d_wdata};

   // Next state; the port just completed is only re-served after the other port
   always_comb begin
      state_n = state;
      cmd_n   = cmd;
      en_n    = en;
      start   = 1'b0;
      inc     = 1'b0;
      go      = 1'b0;
      sel     = SEL_IF;
      case (state)
         IDLE: begin
            if (bus.d_req) begin
               go  = 1'b1;
               sel = SEL_D;
            end else if (bus.if_req) begin
               go  = 1'b1;
               sel = SEL_IF;
            end
         end
         BUSY_IF: begin
            if (!done_c) begin
               inc = 1'b1;
            end else if (bus.d_req) begin
               go  = 1'b1;
               sel = SEL_D;
            end else begin
               state_n  = IDLE;
               en_n     = 1'b0;
               cmd_n.we = 1'b0;
            end
         end
         BUSY_D: begin
            if (!done_c) begin
               inc = 1'b1;
            end else if (bus.if_req) begin
               go  = 1'b1;
               sel = SEL_IF;
            end else begin
               state_n  = IDLE;
               en_n     = 1'b0;
               cmd_n.we = 1'b0;
            end
         end
         default: begin
            state_n = IDLE;
            en_n    = 1'b0;
            cmd_n   = '0;
         end
      endcase
      if (go) begin
         state_n = (sel == SEL_D) ? BUSY_D : BUSY_IF;
         cmd_n   = (sel == SEL_D) ? d_cmd : if_cmd;
         en_n    = 1'b1;
         start   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!startin) begin
         state          <= IDLE;
         cmd            <= '0;
         en             <= 1'b0;
         contention_cnt <= '0;
      end else begin
         state <= state_n;
         cmd   <= cmd_n;
         en    <= en_n;
         if (bus.if_stall && bus.d_stall && (contention_cnt != {CNT_W{1'b1}}))
            contention_cnt <= contention_cnt + CNT_W'(1);
      end
   end

   assign bus.mem_en    = en;
   assign bus.mem_we    = cmd.we;
   assign bus.mem_addr  = cmd.addr;
   assign bus.mem_wdata = cmd.wdata;

   // Ready is gated by the live request so a withdrawn access is silently dropped
   assign cmp_if       = (state == BUSY_IF) && done_c;
   assign cmp_d        = (state == BUSY_D) && done_c;
   assign bus.if_ready = cmp_if && bus.if_req;
   assign bus.d_ready  = cmp_d && bus.d_req;
   assign bus.if_rdata = cmp_if ? bus.mem_rdata : DATA_W'(0);
   assign bus.d_rdata  = (cmp_d && !cmd.we) ? bus.mem_rdata : DATA_W'(0);
   assign bus.if_stall = bus.if_req && !bus.if_ready;
   assign bus.d_stall  = bus.d_req && !bus.d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter at latencies 1, 2, 3 and a 2-bit contention counter.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic clk = 1'b0;
   logic startin = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [31:0] iq[$];
   logic [31:0] dq[$];

   mem_port_arbiter_if b2();
   mem_port_arbiter_if b3();
   mem_port_arbiter_if bs();
   mem_port_arbiter_if b1();
   logic [15:0] cc2, cc3, cc1;
   logic [1:0]  ccs;

   mem_port_arbiter #(.MEM_LATENCY(2), .CNT_W(16)) u2 (.clk(clk), .startin(startin), .bus(b2.slave), .contention_cnt(cc2));
   mem_port_arbiter #(.MEM_LATENCY(3), .CNT_W(16)) u3 (.clk(clk), .startin(startin), .bus(b3.slave), .contention_cnt(cc3));
   mem_port_arbiter #(.MEM_LATENCY(2), .CNT_W(2))  us (.clk(clk), .startin(startin), .bus(bs.slave), .contention_cnt(ccs));
   mem_port_arbiter #(.MEM_LATENCY(1), .CNT_W(16)) u1 (.clk(clk), .startin(startin), .bus(b1.slave), .contention_cnt(cc1));

   // Memory contents: one fixed instruction word, address-derived data elsewhere
   function automatic logic [31:0] mem_data(input logic [31:0] a);
      if (a == 32'h40) return 32'h8C020004;
      return {a[15:0], ~a[15:0]};
   endfunction

   assign b2.mem_rdata = b2.mem_en ? mem_data(b2.mem_addr) : 32'h0;
   assign b3.mem_rdata = b3.mem_en ? mem_data(b3.mem_addr) : 32'h0;
   assign bs.mem_rdata = bs.mem_en ? mem_data(bs.mem_addr) : 32'h0;
   assign b1.mem_rdata = b1.mem_en ? mem_data(b1.mem_addr) : 32'h0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      b2.if_req = 0; b2.if_addr = 0; b2.d_req = 0; b2.d_we = 0; b2.d_addr = 0; b2.d_wdata = 0;
      b3.if_req = 0; b3.if_addr = 0; b3.d_req = 0; b3.d_we = 0; b3.d_addr = 0; b3.d_wdata = 0;
      bs.if_req = 0; bs.if_addr = 0; bs.d_req = 0; bs.d_we = 0; bs.d_addr = 0; bs.d_wdata = 0;
      b1.if_req = 0; b1.if_addr = 0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0; b1.d_wdata = 0;
   endtask

   task automatic test_reset();
      startin = 0;
      step();
      step();
      @(negedge clk);
      total++; if (b2.mem_en !== 1'b0) begin bad++; $display("FAIL reset_mem_en got=%b exp=0", b2.mem_en); end
      total++; if (b2.mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b exp=0", b2.mem_we); end
      total++; if (b2.mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", b2.mem_addr); end
      total++; if ({b2.if_ready, b2.d_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", {b2.if_ready, b2.d_ready}); end
      total++; if (cc2 !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cc2); end
      step();
      startin = 1;
   endtask

   task automatic test_fetch();
      logic [31:0] exp;
      bit got = 0;
      step();
      b2.if_addr = 32'h40; b2.if_req = 1;
      iq.push_back(32'h8C020004);
      for (int c = 0; c < 8 && !got; c++) begin
         @(negedge clk);
         total++; if (b2.if_stall !== (c < 2)) begin bad++; $display("FAIL fetch_stall c=%0d got=%b exp=%b", c, b2.if_stall, (c < 2)); end
         if (c >= 1) begin
            total++; if (b2.mem_addr !== 32'h40) begin bad++; $display("FAIL fetch_addr c=%0d got=%h exp=40", c, b2.mem_addr); end
         end
         if (b2.if_ready) begin
            got = 1;
            exp = (iq.size() > 0) ? iq.pop_front() : 32'hxxxxxxxx;
            total++; if (c != 2 || b2.if_rdata !== exp) begin bad++; $display("FAIL fetch_ready c=%0d exp_c=2 got=%h exp=%h", c, b2.if_rdata, exp); end
         end else step();
      end
      if (!got) begin total++; bad++; $display("FAIL fetch_timeout got=no_ready exp=ready"); end
      step();
      b2.if_req = 0;
   endtask

   task automatic test_contention();
      logic [31:0] exp;
      bit got = 0, ddone = 0;
      step();
      b2.d_req = 1; b2.d_we = 0; b2.d_addr = 32'h100; b2.if_req = 1; b2.if_addr = 32'h44;
      dq.push_back(mem_data(32'h100));
      iq.push_back(mem_data(32'h44));
      for (int c = 0; c < 12 && !got; c++) begin
         @(negedge clk);
         total++; if (b2.if_stall !== (c < 4)) begin bad++; $display("FAIL cont_if_stall c=%0d got=%b exp=%b", c, b2.if_stall, (c < 4)); end
         if (c == 3) begin
            total++; if (b2.mem_addr !== 32'h44) begin bad++; $display("FAIL cont_addr got=%h exp=44", b2.mem_addr); end
         end
         if (b2.d_ready) begin
            ddone = 1;
            exp = (dq.size() > 0) ? dq.pop_front() : 32'hxxxxxxxx;
            total++; if (c != 2 || b2.d_rdata !== exp) begin bad++; $display("FAIL cont_d_ready c=%0d exp_c=2 got=%h exp=%h", c, b2.d_rdata, exp); end
         end
         if (b2.if_ready) begin
            got = 1;
            exp = (iq.size() > 0) ? iq.pop_front() : 32'hxxxxxxxx;
            total++; if (c != 4 || b2.if_rdata !== exp) begin bad++; $display("FAIL cont_if_ready c=%0d exp_c=4 got=%h exp=%h", c, b2.if_rdata, exp); end
            total++; if (cc2 !== 16'd2) begin bad++; $display("FAIL cont_cnt got=%0d exp=2", cc2); end
         end else begin
            step();
            if (ddone) b2.d_req = 0;
         end
      end
      if (!got) begin total++; bad++; $display("FAIL cont_timeout got=no_ready exp=ready"); end
      step();
      b2.if_req = 0; b2.d_req = 0;
   endtask

   task automatic test_store();
      logic [31:0] exp;
      bit got = 0;
      step();
      b2.d_req = 1; b2.d_we = 1; b2.d_addr = 32'h200; b2.d_wdata = 32'hDEADBEEF;
      dq.push_back(32'h0);
      for (int c = 0; c < 8 && !got; c++) begin
         @(negedge clk);
         if (c == 1 || c == 2) begin
            total++; if ({b2.mem_we, b2.mem_wdata} !== {1'b1, 32'hDEADBEEF}) begin bad++; $display("FAIL store_wr c=%0d got=%b/%h exp=1/deadbeef", c, b2.mem_we, b2.mem_wdata); end
         end
         if (b2.d_ready) begin
            got = 1;
            exp = (dq.size() > 0) ? dq.pop_front() : 32'hxxxxxxxx;
            total++; if (c != 2 || b2.d_rdata !== exp) begin bad++; $display("FAIL store_ready c=%0d exp_c=2 got=%h exp=%h", c, b2.d_rdata, exp); end
         end else step();
      end
      if (!got) begin total++; bad++; $display("FAIL store_timeout got=no_ready exp=ready"); end
      step();
      b2.d_req = 0; b2.d_we = 0;
   endtask

   task automatic test_withdraw();
      logic [31:0] exp;
      bit got = 0;
      step();
      b3.if_req = 1; b3.if_addr = 32'h80;
      for (int c = 0; c < 12 && !got; c++) begin
         @(negedge clk);
         total++; if (b3.if_ready !== 1'b0) begin bad++; $display("FAIL wd_if_ready c=%0d got=%b exp=0", c, b3.if_ready); end
         if (c == 3) begin
            total++; if ({b3.mem_en, b3.mem_addr} !== {1'b1, 32'h80}) begin bad++; $display("FAIL wd_runs got=%b/%h exp=1/80", b3.mem_en, b3.mem_addr); end
         end
         if (c >= 4) begin
            total++; if ({b3.mem_en, b3.mem_addr} !== {1'b1, 32'h300}) begin bad++; $display("FAIL wd_d_grant c=%0d got=%b/%h exp=1/300", c, b3.mem_en, b3.mem_addr); end
         end
         if (b3.d_ready) begin
            got = 1;
            exp = (dq.size() > 0) ? dq.pop_front() : 32'hxxxxxxxx;
            total++; if (c != 6 || b3.d_rdata !== exp) begin bad++; $display("FAIL wd_d_ready c=%0d exp_c=6 got=%h exp=%h", c, b3.d_rdata, exp); end
         end else begin
            step();
            if (c == 0) b3.if_req = 0;
            if (c == 1) begin
               b3.d_req = 1; b3.d_we = 0; b3.d_addr = 32'h300;
               dq.push_back(mem_data(32'h300));
            end
         end
      end
      if (!got) begin total++; bad++; $display("FAIL wd_timeout got=no_ready exp=ready"); end
      step();
      b3.d_req = 0;
   endtask

   task automatic test_reset_mid();
      logic [31:0] exp;
      bit got = 0;
      step();
      b2.d_req = 1; b2.d_we = 0; b2.d_addr = 32'h180;
      step();
      startin = 0;
      @(negedge clk);
      total++; if (b2.d_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_c1 got=%b exp=0", b2.d_ready); end
      step();
      startin = 1;
      @(negedge clk);
      total++; if ({b2.mem_en, b2.mem_we, b2.mem_addr, b2.mem_wdata} !== 66'h0) begin bad++; $display("FAIL rst_mid_mem got=%b/%b/%h/%h exp=0", b2.mem_en, b2.mem_we, b2.mem_addr, b2.mem_wdata); end
      total++; if ({b2.d_ready, b2.d_rdata} !== 33'h0) begin bad++; $display("FAIL rst_mid_ready got=%b/%h exp=0", b2.d_ready, b2.d_rdata); end
      total++; if (cc2 !== 16'h0) begin bad++; $display("FAIL rst_mid_cnt got=%0d exp=0", cc2); end
      dq.push_back(mem_data(32'h180));
      for (int c = 3; c < 12 && !got; c++) begin
         step();
         @(negedge clk);
         if (b2.d_ready) begin
            got = 1;
            exp = (dq.size() > 0) ? dq.pop_front() : 32'hxxxxxxxx;
            total++; if (c != 4 || b2.d_rdata !== exp) begin bad++; $display("FAIL rst_mid_regrant c=%0d exp_c=4 got=%h exp=%h", c, b2.d_rdata, exp); end
         end
      end
      if (!got) begin total++; bad++; $display("FAIL rst_mid_timeout got=no_ready exp=ready"); end
      step();
      b2.d_req = 0;
   endtask

   task automatic test_saturate();
      logic [31:0] exp;
      int ncont = 0;
      step();
      bs.if_req = 1; bs.if_addr = 32'h500; bs.d_req = 1; bs.d_we = 0; bs.d_addr = 32'h600;
      for (int k = 0; k < 3; k++) begin
         dq.push_back(mem_data(32'h600));
         iq.push_back(mem_data(32'h500));
      end
      for (int c = 0; c < 13; c++) begin
         @(negedge clk);
         total++; if (ccs !== 2'((ncont > 3) ? 3 : ncont)) begin bad++; $display("FAIL sat_cnt c=%0d got=%0d exp=%0d", c, ccs, (ncont > 3) ? 3 : ncont); end
         total++; if ({bs.d_ready, bs.if_ready} !== {(c % 4 == 2), (c > 0 && c % 4 == 0)}) begin bad++; $display("FAIL sat_ready c=%0d got=%b%b", c, bs.d_ready, bs.if_ready); end
         if (bs.d_ready) begin
            exp = (dq.size() > 0) ? dq.pop_front() : 32'hxxxxxxxx;
            total++; if (bs.d_rdata !== exp) begin bad++; $display("FAIL sat_d_rdata c=%0d got=%h exp=%h", c, bs.d_rdata, exp); end
         end
         if (bs.if_ready) begin
            exp = (iq.size() > 0) ? iq.pop_front() : 32'hxxxxxxxx;
            total++; if (bs.if_rdata !== exp) begin bad++; $display("FAIL sat_if_rdata c=%0d got=%h exp=%h", c, bs.if_rdata, exp); end
         end
         if (c == 0 || c % 2 == 1) ncont++;
         step();
      end
      total++; if (iq.size() + dq.size() != 0) begin bad++; $display("FAIL sat_missing got=%0d exp=0", iq.size() + dq.size()); end
      bs.if_req = 0; bs.d_req = 0;
   endtask

   task automatic test_back_to_back();
      step();
      b1.if_req = 1; b1.if_addr = 32'h700; b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h704;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (c >= 1) begin
            total++; if (b1.mem_addr !== ((c % 2 == 1) ? 32'h704 : 32'h700)) begin bad++; $display("FAIL b2b_addr c=%0d got=%h", c, b1.mem_addr); end
            total++; if ({b1.d_ready, b1.if_ready} !== {(c % 2 == 1), (c % 2 == 0)}) begin bad++; $display("FAIL b2b_ready c=%0d got=%b%b", c, b1.d_ready, b1.if_ready); end
         end
         if (c == 7) begin
            total++; if (cc1 !== 16'd1) begin bad++; $display("FAIL b2b_cnt got=%0d exp=1", cc1); end
         end
         step();
      end
      b1.if_req = 0; b1.d_req = 0;
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_fetch();
      test_contention();
      test_store();
      test_withdraw();
      test_reset_mid();
      test_saturate();
      test_back_to_back();
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
